gpio_seq_ctrl: RTL and testbench
================================

// Module: gpio_seq_ctrl
// PURPOSE
//  Bus-side controller for the gpio peripheral: sits between the CPU data bus and
//  the gpio write port, and owns that port. The CPU writes GPIO state directly via
//  DATA, or loads a pattern table that the block plays out autonomously, one
//  pattern per programmable interval, once or looping.
// PARAMETERS
//  DEPTH     8   pattern table entries (1..8)
//  PERIOD_W  24  width of step-interval counter/register
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   asynchronous active-low reset
//  addr     in   8   CPU byte address within block
//  be       in   4   CPU byte enables
//  wdata    in   32  CPU write data
//  we       in   1   CPU write strobe, one cycle per access
//  q        out  32  CPU read data (combinational from addr)
//  g_addr   out  8   gpio peripheral address, constant 8'h00
//  g_be     out  4   gpio byte enables
//  g_wdata  out  32  gpio write data
//  g_we     out  1   gpio write strobe, one-cycle pulse
//  busy     out  1   sequencer running
// BEHAVIOUR
//  Regs (word aligned; be honoured per byte on all writes):
//   0x00 DATA    last value written to gpio (RW)
//   0x04 CTRL    [0]RUN [1]LOOP (RW); RUN 0->1 starts, 1->0 aborts
//   0x08 PERIOD  cycles between steps, [PERIOD_W-1:0]; 0 treated as 1
//   0x0C LEN     steps, [3:0]; 0 treated as 1, >DEPTH clamped to DEPTH
//   0x10 STATUS  [0]DONE [1]DROP, sticky, write-1-to-clear; [7:4] current index
//   0x20+4*i PAT[i], i<DEPTH; other addresses read 0, writes ignored
//  Reset: all regs 0, g_we=0, g_be=0, g_wdata=0, g_addr=0, busy=0, FSM IDLE.
//  FSM IDLE -> STEP (RUN rising) -> WAIT -> STEP ... ; STEP->IDLE when last
//   step issued and LOOP=0 (sets DONE, clears RUN); index wraps to 0 if LOOP=1.
//  STEP: one cycle; g_we=1, g_be=4'hF, g_wdata=PAT[idx], DATA<=PAT[idx].
//  WAIT: counter loads max(PERIOD,1)-1, counts to 0; g_we pulses exactly
//   max(PERIOD,1) cycles apart. PERIOD/LEN sampled at each STEP.
//  Latency: CPU write of RUN=1 in cycle T -> first g_we in cycle T+1.
//  Direct path: CPU DATA write in IDLE -> g_we in same cycle, g_be=be,
//   g_wdata=wdata (combinational pass-through); DATA updated at clock edge.
//  Arbitration: while busy, sequencer owns port; CPU DATA writes dropped, set DROP.
//  Abort: RUN cleared mid-run -> IDLE next edge, no further g_we, DATA keeps last
//   pattern, DONE not set. Abort write coincident with STEP: that STEP completes.
//  CPU write to PAT[idx] while running takes effect at next use of that entry.
//  RUN=1 written while already busy: no restart. Reset mid-run: immediate IDLE.
// STRUCTURE
//  Package gpio_seq_pkg: register offsets, CTRL/STATUS bit positions, FSM state enum.
//  Single module; pattern table as reg array; no sub-modules.
// TESTING
//  Reset: rst_n=0 mid-run -> all outputs 0, busy=0, q(DATA)=0.
//  Direct: IDLE, write DATA=0x5 be=F -> g_we=1 same cycle, g_wdata=0x5; read DATA=0x5.
//  One-shot: PAT0..2=1,2,4, LEN=3, PERIOD=4, RUN=1 at T -> g_we at T+1,T+5,T+9;
//   DONE=1, RUN=0, busy=0 at T+10.
//  Loop: LEN=2, LOOP=1, PERIOD=0 -> g_wdata alternates PAT0,PAT1 every cycle.
//  Abort+drop: run, write DATA=0xA -> DROP=1, no g_we with 0xA; clear RUN ->
//   no further g_we; W1C STATUS -> DROP=0.
//  Clamp: LEN=0 -> single step; LEN=15 -> DEPTH steps then DONE.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: shared definitions for the gpio sequencer controller.
//   - register byte offsets and the pattern-table base
//   - CTRL / STATUS bit positions
//   - sequencer FSM state encoding
//   - helpers: byte-enable merge and effective step count
package gpio_seq_pkg;

    localparam logic [7:0] ADDR_DATA     = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h04;
    localparam logic [7:0] ADDR_PERIOD   = 8'h08;
    localparam logic [7:0] ADDR_LEN      = 8'h0C;
    localparam logic [7:0] ADDR_STATUS   = 8'h10;
    localparam logic [7:0] ADDR_PAT_BASE = 8'h20;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_LOOP    = 1;
    localparam int STAT_DONE    = 0;
    localparam int STAT_DROP    = 1;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_e;

    // Replace only the bytes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    // LEN of 0 runs one step; anything beyond the table runs the whole table.
    function automatic logic [3:0] eff_len(input logic [3:0] len, input int depth);
        if (len == 4'd0) return 4'd1;
        if (int'(len) > depth) return 4'(depth);
        return len;
    endfunction

endpackage

// File: rtl/gpio_seq_ctrl_if.sv
// gpio_seq_ctrl_if: CPU-side register bus plus the gpio write port.
//   CPU bus : addr, be, wdata, we (in to controller), q (read data out)
//   gpio    : g_addr, g_be, g_wdata, g_we (out of controller)
//   status  : busy, dbg_state (sequencer FSM state for observation)
//
// Handshake: there is no ready. we is a one-cycle strobe and every write is
// accepted in the cycle it is presented; q is combinational from addr. g_we
// is a one-cycle strobe the gpio port must accept unconditionally.
interface gpio_seq_ctrl_if;
    import gpio_seq_pkg::*;

    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] q;

    logic [7:0]  g_addr;
    logic [3:0]  g_be;
    logic [31:0] g_wdata;
    logic        g_we;
    logic        busy;
    seq_state_e  dbg_state;

    modport master (
        output addr, be, wdata, we,
        input  q, g_addr, g_be, g_wdata, g_we, busy, dbg_state
    );

    modport slave (
        input  addr, be, wdata, we,
        output q, g_addr, g_be, g_wdata, g_we, busy, dbg_state
    );

endinterface

// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl: owns the gpio write port. The CPU either writes DATA, which
// passes straight through to the port while the sequencer is idle, or loads a
// pattern table that is played out one entry per PERIOD cycles, once or looping.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    gpio_seq_ctrl_if.slave (CPU register bus, gpio port, busy, dbg_state)
module gpio_seq_ctrl
    import gpio_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    gpio_seq_ctrl_if.slave bus
);

    localparam int IDX_W = 3;

    seq_state_e          state_q;
    logic [31:0]         data_q;
    logic                run_q;
    logic                loop_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [3:0]          len_q;
    logic [3:0]          idx_q;
    logic                done_q;
    logic                drop_q;
    logic [31:0]         pat_q [DEPTH];

    // Register decode
    logic             pat_hit;
    logic [IDX_W-1:0] pat_sel;
    logic             wr_data, wr_ctrl, wr_period, wr_len, wr_status, wr_pat;

    assign pat_hit   = ((bus.addr & 8'hE3) == ADDR_PAT_BASE) && (int'(bus.addr[4:2]) < DEPTH);
    assign pat_sel   = bus.addr[4:2];
    assign wr_data   = bus.we && (bus.addr == ADDR_DATA);
    assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL) && bus.be[0];
    assign wr_period = bus.we && (bus.addr == ADDR_PERIOD);
    assign wr_len    = bus.we && (bus.addr == ADDR_LEN) && bus.be[0];
    assign wr_status = bus.we && (bus.addr == ADDR_STATUS) && bus.be[0];
    assign wr_pat    = bus.we && pat_hit;

    // Sequencer control terms
    logic                idle, step, last_step, start, abort, finish;
    logic [3:0]          len_eff;
    logic [PERIOD_W-1:0] per_eff;
    logic [31:0]         step_data;

    assign idle      = (state_q == ST_IDLE);
    assign step      = (state_q == ST_STEP);
    assign len_eff   = eff_len(len_q, DEPTH);
    // >= rather than == so a LEN shrunk mid-run still terminates/wraps.
    assign last_step = (idx_q >= (len_eff - 4'd1));
    assign per_eff   = (period_q == '0) ? PERIOD_W'(1) : period_q;
    assign start     = idle && wr_ctrl && bus.wdata[CTRL_RUN] && !run_q;
    assign abort     = !idle && wr_ctrl && !bus.wdata[CTRL_RUN];
    assign finish    = step && last_step && !loop_q && !abort;
    assign step_data = pat_q[idx_q[IDX_W-1:0]];

    // Sequencer FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_STEP;
                        idx_q   <= '0;
                    end
                end
                ST_STEP: begin
                    // The STEP itself always completes; abort only stops what follows.
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= last_step ? 4'd0 : idx_q + 4'd1;
                        if (last_step && !loop_q) begin
                            state_q <= ST_IDLE;
                        end else if (per_eff == PERIOD_W'(1)) begin
                            state_q <= ST_STEP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= per_eff - PERIOD_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // cnt reaches 0 as the next STEP is entered.
                        cnt_q <= cnt_q - PERIOD_W'(1);
                        if (cnt_q == PERIOD_W'(1)) state_q <= ST_STEP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // CPU-visible registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            period_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
        end else begin
            if (step) begin
                data_q <= step_data;
            end else if (wr_data && idle) begin
                data_q <= be_merge(data_q, bus.wdata, bus.be);
            end

            if (wr_ctrl) begin
                loop_q <= bus.wdata[CTRL_LOOP];
                // While busy only a clear of RUN (abort) has an effect.
                if (idle || !bus.wdata[CTRL_RUN]) run_q <= bus.wdata[CTRL_RUN];
            end
            if (finish) run_q <= 1'b0;

            if (wr_period) period_q <= PERIOD_W'(be_merge(32'(period_q), bus.wdata, bus.be));
            if (wr_len)    len_q    <= bus.wdata[3:0];
            if (wr_pat)    pat_q[pat_sel] <= be_merge(pat_q[pat_sel], bus.wdata, bus.be);

            // Sticky flags: a hardware set wins over a coincident clear.
            if (finish) begin
                done_q <= 1'b1;
            end else if (wr_status && bus.wdata[STAT_DONE]) begin
                done_q <= 1'b0;
            end
            if (wr_data && !idle) begin
                drop_q <= 1'b1;
            end else if (wr_status && bus.wdata[STAT_DROP]) begin
                drop_q <= 1'b0;
            end
        end
    end

    // gpio port: sequencer STEP, else direct CPU pass-through while idle.
    always_comb begin
        bus.g_we    = 1'b0;
        bus.g_be    = 4'h0;
        bus.g_wdata = '0;
        if (step) begin
            bus.g_we    = 1'b1;
            bus.g_be    = 4'hF;
            bus.g_wdata = step_data;
        end else if (idle && wr_data) begin
            bus.g_we    = 1'b1;
            bus.g_be    = bus.be;
            bus.g_wdata = bus.wdata;
        end
    end

    assign bus.g_addr    = 8'h00;
    assign bus.busy      = !idle;
    assign bus.dbg_state = state_q;

    // Read mux
    always_comb begin
        bus.q = '0;
        if (pat_hit) begin
            bus.q = pat_q[pat_sel];
        end else begin
            case (bus.addr)
                ADDR_DATA:   bus.q = data_q;
                ADDR_CTRL: begin
                    bus.q[CTRL_RUN]  = run_q;
                    bus.q[CTRL_LOOP] = loop_q;
                end
                ADDR_PERIOD: bus.q[PERIOD_W-1:0] = period_q;
                ADDR_LEN:    bus.q[3:0] = len_q;
                ADDR_STATUS: begin
                    bus.q[STAT_DONE]           = done_q;
                    bus.q[STAT_DROP]           = drop_q;
                    bus.q[STAT_IDX_LSB +: 4]   = idx_q;
                end
                default: bus.q = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
module tb_gpio_seq_ctrl;
    import gpio_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int EW    = 52;  // {cycle[15:0], be[3:0], data[31:0]}

    logic clk;
    logic rst_n;
    gpio_seq_ctrl_if bus();

    gpio_seq_ctrl #(.DEPTH(DEPTH), .PERIOD_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [31:0]   model_pat[DEPTH];
    logic [31:0]   model_data;

    // ---------------- clock / reset / monitor ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.g_we === 1'b1)
            obs_q.push_back({cyc[15:0], bus.g_be, bus.g_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_len(input int len);
        if (len == 0) return 1;
        if (len > DEPTH) return DEPTH;
        return len;
    endfunction

    function automatic int m_per(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    // Step k of a run started by the RUN write in cycle start lands in
    // cycle start+1+k*period and carries entry k mod len.
    function automatic void push_expected(input int start, input int len, input int per, input int nsteps);
        for (int k = 0; k < nsteps; k++) begin
            logic [15:0] c16;
            c16 = 16'(start + 1 + k * m_per(per));
            exp_q.push_back({c16, 4'hF, model_pat[k % m_len(len)]});
        end
    endfunction

    // Steps issued up to and including the cycle of an abort write.
    function automatic int steps_before(input int start, input int len, input int per,
                                        input bit loop_en, input int abort_cyc);
        int n;
        n = (abort_cyc - start - 1) / m_per(per) + 1;
        if (!loop_en && n > m_len(len)) n = m_len(len);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                             output int wcyc);
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        bus.we    = 1'b1;
        wcyc      = cyc;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.be    = 4'h0;
        bus.wdata = '0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
        bus.addr = a;
        @(negedge clk);
        d = bus.q;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pats();
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            model_pat[i] = $urandom;
            cpu_write(8'(32 + 4 * i), model_pat[i], 4'hF, w);
        end
    endtask

    task automatic start_run(input int len, input int per, input bit loop_en, output int t);
        int w;
        cpu_write(ADDR_LEN, 32'(len), 4'hF, w);
        cpu_write(ADDR_PERIOD, 32'(per), 4'hF, w);
        obs_q.delete();
        exp_q.delete();
        cpu_write(ADDR_CTRL, {30'd0, loop_en, 1'b1}, 4'hF, t);
    endtask

    task automatic drain(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (bus.busy === 1'b1) begin
            if (n >= 2000) begin
                ok = 1'b0;
                break;
            end
            wait_cycles(1);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        total_cnt++;
        if (bus.g_we !== 1'b0 || bus.g_be !== 4'h0 || bus.g_wdata !== 32'h0 || bus.g_addr !== 8'h0)
            $display("FAIL reset_port: got we=%b be=%h wdata=%h addr=%h required all 0",
                     bus.g_we, bus.g_be, bus.g_wdata, bus.g_addr);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE)
            $display("FAIL reset_busy: got busy=%b state=%0d required 0/IDLE", bus.busy, bus.dbg_state);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = (i == 5) ? 8'h3C : 8'(4 * i);
            cpu_read(a, r);
            total_cnt++;
            if (r !== 32'h0) $display("FAIL reset_reg: addr=%h got %h required 0", a, r);
            else pass_cnt++;
        end
    endtask

    task automatic test_direct();
        int w;
        logic [31:0] r, d;
        logic [3:0]  b;
        obs_q.delete();
        exp_q.delete();
        model_data = 32'h0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin d = 32'h5; b = 4'hF; end
            else if (i == 1) begin d = 32'hAABBCCDD; b = 4'h2; end
            else begin d = $urandom; b = 4'($urandom_range(0, 15)); end
            cpu_write(ADDR_DATA, d, b, w);
            exp_q.push_back({16'(w), b, d});
            for (int k = 0; k < 4; k++) if (b[k]) model_data[8*k +: 8] = d[8*k +: 8];
            cpu_read(ADDR_DATA, r);
            total_cnt++;
            if (r !== model_data) $display("FAIL direct_data_%0d: got %h required %h", i, r, model_data);
            else pass_cnt++;
        end
        // Unmapped address (just past the table): write ignored, reads 0.
        cpu_write(8'h40, 32'hDEADBEEF, 4'hF, w);
        cpu_read(8'h40, r);
        total_cnt++;
        if (r !== 32'h0) $display("FAIL direct_unmapped: got %h required 0", r);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL direct_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [EW-1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL direct_event: got cyc=%0d be=%h data=%h required cyc=%0d be=%h data=%h",
                                  o[51:36], o[35:32], o[31:0], e[51:36], e[35:32], e[31:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_one_shot();
        int w, t;
        logic [31:0] r;
        model_pat[0] = 32'h1;
        model_pat[1] = 32'h2;
        model_pat[2] = 32'h4;
        for (int i = 0; i < 3; i++) cpu_write(8'(32 + 4 * i), model_pat[i], 4'hF, w);
        start_run(3, 4, 1'b0, t);
        push_expected(t, 3, 4, 3);
        wait_cycles(8);  // now in cycle t+9, the final STEP
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL one_shot_busy_t9: got %b required 1", bus.busy);
        else pass_cnt++;
        wait_cycles(1);  // cycle t+10
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL one_shot_idle_t10: got %b required 0", bus.busy);
        else pass_cnt++;
        cpu_read(ADDR_STATUS, r);
        total_cnt++;
        if (r[1:0] !== 2'b01) $display("FAIL one_shot_done: got status=%h required done=1 drop=0", r);
        else pass_cnt++;
        cpu_read(ADDR_CTRL, r);
        total_cnt++;
        if (r[0] !== 1'b0) $display("FAIL one_shot_run_clear: got ctrl=%h required run=0", r);
        else pass_cnt++;
        cpu_read(ADDR_DATA, r);
        total_cnt++;
        if (r !== 32'h4) $display("FAIL one_shot_data: got %h required 4", r);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL one_shot_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [EW-1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL one_shot_event: got cyc=%0d be=%h data=%h required cyc=%0d be=%h data=%h",
                                  o[51:36], o[35:32], o[31:0], e[51:36], e[35:32], e[31:0]);
            else pass_cnt++;
        end
        cpu_write(ADDR_STATUS, 32'h1, 4'h1, w);
        cpu_read(ADDR_STATUS, r);
        total_cnt++;
        if (r[0] !== 1'b0) $display("FAIL one_shot_w1c: got status=%h required done=0", r);
        else pass_cnt++;
    endtask

    task automatic test_loop();
        int t, a, n;
        logic [31:0] r;
        load_pats();
        start_run(2, 0, 1'b1, t);
        wait_cycles($urandom_range(4, 12));
        cpu_write(ADDR_CTRL, 32'h2, 4'hF, a);  // clear RUN, keep LOOP
        n = steps_before(t, 2, 0, 1'b1, a);
        push_expected(t, 2, 0, n);
        wait_cycles(10);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL loop_abort_idle: got busy=%b required 0", bus.busy);
        else pass_cnt++;
        cpu_read(ADDR_STATUS, r);
        total_cnt++;
        if (r[0] !== 1'b0) $display("FAIL loop_abort_done: got status=%h required done=0", r);
        else pass_cnt++;
        cpu_read(ADDR_DATA, r);
        total_cnt++;
        if (r !== model_pat[(n - 1) % 2]) $display("FAIL loop_data: got %h required %h", r, model_pat[(n - 1) % 2]);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL loop_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [EW-1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL loop_event: got cyc=%0d be=%h data=%h required cyc=%0d be=%h data=%h",
                                  o[51:36], o[35:32], o[31:0], e[51:36], e[35:32], e[31:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort_drop();
        int t, w, a, n;
        logic [31:0] r;
        load_pats();
        start_run(4, 5, 1'b0, t);
        wait_cycles(2);
        cpu_write(ADDR_DATA, 32'hA, 4'hF, w);  // dropped: sequencer owns the port
        cpu_read(ADDR_STATUS, r);
        total_cnt++;
        if (r[1] !== 1'b1) $display("FAIL drop_set: got status=%h required drop=1", r);
        else pass_cnt++;
        cpu_write(ADDR_CTRL, 32'h0, 4'hF, a);
        n = steps_before(t, 4, 5, 1'b0, a);
        push_expected(t, 4, 5, n);
        wait_cycles(20);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL abort_idle: got busy=%b required 0", bus.busy);
        else pass_cnt++;
        cpu_read(ADDR_DATA, r);
        total_cnt++;
        if (r !== model_pat[n - 1]) $display("FAIL abort_data: got %h required %h", r, model_pat[n - 1]);
        else pass_cnt++;
        cpu_write(ADDR_STATUS, 32'h2, 4'h1, w);
        cpu_read(ADDR_STATUS, r);
        total_cnt++;
        if (r[1:0] !== 2'b00) $display("FAIL drop_w1c: got status=%h required done=0 drop=0", r);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL abort_count: got %0d required %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [EW-1:0] o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o !== e) $display("FAIL abort_event: got cyc=%0d be=%h data=%h required cyc=%0d be=%h data=%h",
                                  o[51:36], o[35:32], o[31:0], e[51:36], e[35:32], e[31:0]);
            else pass_cnt++;
        end
    endtask

    // Clamp cases first, then randomized back-to-back one-shot runs; odd
    // runs rewrite RUN=1 while busy, which must not restart the sequence.
    task automatic test_back_to_back();
        int t, w, len, per;
        bit ok;
        logic [31:0] r;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin len = 0; per = 3; end
            else if (it == 1) begin len = 15; per = 2; end
            else begin len = $urandom_range(0, 15); per = $urandom_range(0, 5); end
            load_pats();
            start_run(len, per, 1'b0, t);
            if (it % 2 == 1) cpu_write(ADDR_CTRL, 32'h1, 4'hF, w);
            push_expected(t, len, per, m_len(len));
            drain(ok);
            total_cnt++;
            if (!ok) $display("FAIL b2b_timeout_%0d: got busy after 2000 cycles required idle", it);
            else pass_cnt++;
            cpu_read(ADDR_STATUS, r);
            total_cnt++;
            if (r[0] !== 1'b1) $display("FAIL b2b_done_%0d: got status=%h required done=1", it, r);
            else pass_cnt++;
            total_cnt++;
            if (obs_q.size() !== exp_q.size())
                $display("FAIL b2b_count_%0d: len=%0d per=%0d got %0d required %0d",
                         it, len, per, obs_q.size(), exp_q.size());
            else pass_cnt++;
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                logic [EW-1:0] o, e;
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                total_cnt++;
                if (o !== e) $display("FAIL b2b_event_%0d: got cyc=%0d be=%h data=%h required cyc=%0d be=%h data=%h",
                                      it, o[51:36], o[35:32], o[31:0], e[51:36], e[35:32], e[31:0]);
                else pass_cnt++;
            end
            cpu_write(ADDR_STATUS, 32'h3, 4'h1, w);
        end
    endtask

    task automatic test_reset_mid_run();
        int t;
        load_pats();
        start_run(8, 1, 1'b1, t);
        wait_cycles(5);
        bus.addr = ADDR_DATA;
        rst_n    = 1'b0;
        #1;
        total_cnt++;
        if (bus.g_we !== 1'b0 || bus.g_be !== 4'h0 || bus.g_wdata !== 32'h0)
            $display("FAIL midrun_reset_port: got we=%b be=%h wdata=%h required all 0",
                     bus.g_we, bus.g_be, bus.g_wdata);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b required 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.q !== 32'h0) $display("FAIL midrun_reset_data: got %h required 0", bus.q);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.addr  = 8'h0;
        bus.be    = 4'h0;
        bus.wdata = 32'h0;
        bus.we    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);

        test_reset();
        test_direct();
        test_one_shot();
        test_loop();
        test_abort_drop();
        test_back_to_back();
        test_reset_mid_run();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
